// File: rtl/fp_stream_pkg.sv
// fp_stream_pkg: shared widths, state and index types for the score streamer
package fp_stream_pkg;
  localparam int DATA_W = 32;
  localparam int IDX_W = 4;
  localparam int DEPTH = 2 ** IDX_W;
  typedef enum logic {FILL, STREAM} stream_state_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0] cnt_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/fp_score_streamer_if.sv
// fp_score_streamer_if: producer write port and comparator-facing stream
interface fp_score_streamer_if;
  import fp_stream_pkg::*;
  logic wr_valid;
  logic wr_ready;
  data_t wr_data;
  logic wr_last;
  logic abort;
  logic out_start;
  logic out_valid;
  data_t out_data;
  idx_t out_index;
  logic out_last;
  logic busy;
  modport slave (
    input wr_valid, wr_data, wr_last, abort,
    output wr_ready, out_start, out_valid, out_data, out_index, out_last, busy
  );
  modport master (
    output wr_valid, wr_data, wr_last, abort,
    input wr_ready, out_start, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/fp_score_ram.sv
// fp_score_ram: simple dual-port score buffer, sync write, registered read
module fp_score_ram
  import fp_stream_pkg::*;
(
  input logic clk,
  input logic we,
  input idx_t waddr,
  input data_t wdata,
  input idx_t raddr,
  output data_t rdata
);
  data_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fp_score_streamer.sv
// fp_score_streamer: buffers a batch of float32 scores and replays them indexed to the argmax comparator
module fp_score_streamer
  import fp_stream_pkg::*;
(
  input logic clk,
  input logic reset,
  fp_score_streamer_if.slave s
);
  localparam cnt_t LAST_SLOT = cnt_t'(DEPTH - 1);
  stream_state_t state;
  cnt_t count, rd_ptr;
  logic vld, start, last, wr_fire, rd_go;
  idx_t idx;
  data_t rd_q;
  assign wr_fire = s.wr_valid && state == FILL && !s.abort;
  assign rd_go = state == STREAM && rd_ptr != count;
  fp_score_ram u_ram (
    .clk(clk),
    .we(wr_fire),
    .waddr(count[IDX_W-1:0]),
    .wdata(s.wr_data),
    .raddr(rd_ptr[IDX_W-1:0]),
    .rdata(rd_q)
  );
  // flags are registered alongside the RAM read so they line up with rd_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
      count <= '0;
      rd_ptr <= '0;
      vld <= 1'b0;
      start <= 1'b0;
      last <= 1'b0;
      idx <= '0;
    end else if (s.abort) begin
      state <= FILL;
      count <= '0;
      rd_ptr <= '0;
      vld <= 1'b0;
      start <= 1'b0;
      last <= 1'b0;
    end else begin
      vld <= rd_go;
      start <= rd_go && rd_ptr == '0;
      last <= rd_go && rd_ptr == cnt_t'(count - 1'b1);
      if (rd_go) idx <= rd_ptr[IDX_W-1:0];
      if (wr_fire) begin
        count <= count + 1'b1;
        if (s.wr_last || count == LAST_SLOT) state <= STREAM;
      end
      if (state == STREAM) begin
        if (rd_go) rd_ptr <= rd_ptr + 1'b1;
        else begin
          state <= FILL;
          count <= '0;
          rd_ptr <= '0;
        end
      end
    end
  end
  assign s.wr_ready = state == FILL;
  assign s.busy = state == STREAM;
  assign s.out_valid = vld;
  assign s.out_start = start;
  assign s.out_last = last;
  assign s.out_index = idx;
  assign s.out_data = vld ? rd_q : '0;
endmodule

// File: tb/tb_fp_score_streamer.sv
// tb_fp_score_streamer: randomized scoreboard bench for the float32 score streamer
module tb_fp_score_streamer;
  typedef struct {
    logic [31:0] d;
    logic [3:0] i;
    logic st;
    logic la;
    int c;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int rdy_cyc = 0;
  exp_t sb[$];
  logic [31:0] bq[$];
  fp_score_streamer_if s();
  fp_score_streamer dut (.clk(clk), .reset(reset), .s(s));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fbits(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d, input logic l);
    int n = 0;
    int c;
    s.wr_valid = 1;
    s.wr_data = d;
    s.wr_last = l;
    while (!s.wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s.wr_ready) begin
      check("wr_timeout", 64'(s.wr_ready), 64'd1);
    end else begin
      bq.push_back(d);
      if (l || bq.size() == 16) begin
        c = cyc;
        foreach (bq[k])
          sb.push_back('{bq[k], 4'(k), k == 0, k == bq.size() - 1, c + 2 + k});
        rdy_cyc = c + 2 + bq.size();
        bq.delete();
      end
    end
    @(negedge clk);
    s.wr_valid = 0;
    s.wr_last = 0;
  endtask

  task automatic wait_rearm(input bit junk);
    bit done = 0;
    bit exp;
    for (int k = 0; k < 60 && !done; k++) begin
      exp = cyc >= rdy_cyc;
      tests++;
      if ({s.wr_ready, s.busy} !== {exp, !exp}) begin
        fails++;
        $display("FAIL rearm: cyc %0d ready/busy got %b%b want %b%b", cyc, s.wr_ready, s.busy, exp, !exp);
        done = 1;
      end else if (exp) done = 1;
      else begin
        if (junk) begin
          s.wr_valid = 1;
          s.wr_data = 32'hDEADBEEF;
        end
        @(negedge clk);
      end
    end
    s.wr_valid = 0;
    if (!done) check("rearm_timeout", 64'(done), 64'd1);
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_idx(input int want);
    int n = 0;
    while (!(s.out_valid && s.out_index == 4'(want)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx", 64'(s.out_index), 64'(want));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && s.out_valid) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL beat: unexpected beat d=%h i=%0d at cyc %0d", s.out_data, s.out_index, cyc);
        end else begin
          e = sb.pop_front();
          if ({s.out_data, s.out_index, s.out_start, s.out_last} !== {e.d, e.i, e.st, e.la} || cyc != e.c) begin
            fails++;
            $display("FAIL beat: got d=%h i=%0d s=%b l=%b cyc=%0d want d=%h i=%0d s=%b l=%b cyc=%0d",
                     s.out_data, s.out_index, s.out_start, s.out_last, cyc, e.d, e.i, e.st, e.la, e.c);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s.wr_valid = 0;
    s.wr_data = '0;
    s.wr_last = 0;
    s.abort = 0;
    #3;
    check("rst_outs", {s.out_valid, s.out_start, s.out_last, s.busy, s.wr_ready}, 64'b00001);
    check("rst_data", {s.out_data, 28'd0, s.out_index}, 64'd0);
    idle(2);
    reset = 1;
    @(negedge clk);
    // full batch of 1.0..16.0 without wr_last
    for (int n = 1; n <= 16; n++) wr(fbits(n), 0);
    wait_rearm(0);
    for (int n = 0; n < 3; n++) wr($urandom, n == 2);
    wait_rearm(0);
    // junk offered throughout the stream
    for (int n = 0; n < 5; n++) wr($urandom, n == 4);
    wait_rearm(1);
    for (int n = 0; n < 16; n++) wr($urandom, 0);
    wait_idx(5);
    s.abort = 1;
    @(negedge clk);
    s.abort = 0;
    check("abort_outs", {s.out_valid, s.busy, s.wr_ready}, 64'b001);
    sb.delete();
    bq.delete();
    wr($urandom, 0);
    wr($urandom, 1);
    wait_rearm(0);
    for (int n = 0; n < 12; n++) wr($urandom, n == 11);
    wait_idx(7);
    reset = 0;
    #1;
    check("mid_rst_outs", {s.out_valid, s.out_start, s.out_last, s.busy, s.wr_ready}, 64'b00001);
    check("mid_rst_data", {s.out_data, 28'd0, s.out_index}, 64'd0);
    sb.delete();
    bq.delete();
    @(negedge clk);
    reset = 1;
    wr(32'h7FC00001, 1);
    wait_rearm(0);
    for (int n = 0; n < 4; n++) begin
      wr($urandom, n == 3);
      if (n < 3) idle(1);
    end
    wait_rearm(0);
    for (int b = 0; b < 8; b++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int n = 0; n < len; n++) begin
        idle($urandom_range(0, 2));
        wr($urandom, n == len - 1 && (len < 16 || $urandom_range(0, 1) == 1));
      end
      wait_rearm(b[0]);
    end
    idle(3);
    check("final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
